// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external W-bit up-counter: loads a start value, enables counting
// until Q reaches a programmed end value, then pulses done. Supports pause and abort.
`timescale 1ns/1ps
module counter_seq_ctrl #(
  parameter int W = 12
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  input  logic [W-1:0] start_val,
  input  logic [W-1:0] end_val,
  input  logic [W-1:0] cnt_q,
  output logic         cnt_en,
  output logic         cnt_load,
  output logic [W-1:0] cnt_d,
  output logic         busy,
  output logic         done,
  output logic         wrapped,
  output logic [W-1:0] steps
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  logic [2:0]   state, state_nxt;
  logic [W-1:0] start_reg, end_reg;
  logic         at_end;
  logic         accept;

  function automatic logic [W-1:0] inc_mod(input logic [W-1:0] v);
    return v + ONE;
  endfunction

  assign at_end = (cnt_q == end_reg);
  assign accept = (state == S_IDLE) && start && !abort;

  // Abort masks the counter controls in the same cycle it is seen.
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_load  = 1'b0;
    cnt_d     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_load  = 1'b1;
          cnt_d     = start_reg;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_en = !pause && !at_end;
          if (at_end)     state_nxt = S_DONE;
          else if (pause) state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        busy = 1'b1;
        if (abort)       state_nxt = S_IDLE;
        else if (!pause) state_nxt = S_RUN;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      start_reg <= '0;
      end_reg   <= '0;
      steps     <= '0;
      wrapped   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        start_reg <= start_val;
        end_reg   <= end_val;
        steps     <= '0;
        wrapped   <= 1'b0;
      end else if (cnt_en) begin
        steps <= inc_mod(steps);
        if (cnt_q == ALL_ONES) wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed and randomized sequences against counter_seq_ctrl driving a behavioural
// up-counter; expectations are derived per sequence from start/end arithmetic.
`timescale 1ns/1ps
module tb_counter_seq_ctrl;
  localparam int W = 12;
  localparam int M = 1 << W;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [W-1:0] start_val = '0, end_val = '0;
  logic [W-1:0] cnt_q = '0;
  logic         cnt_en, cnt_load, busy, done, wrapped;
  logic [W-1:0] cnt_d, steps;

  int vectors = 0;
  int miscompares = 0;

  counter_seq_ctrl #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .pause(pause),
    .start_val(start_val), .end_val(end_val), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_d(cnt_d), .busy(busy),
    .done(done), .wrapped(wrapped), .steps(steps)
  );

  always #5 CLK = ~CLK;

  // The external counter the controller drives.
  always @(posedge CLK) begin
    if (cnt_load)    cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_q + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  task automatic scramble;
    start     = 1'($urandom_range(0, 1));
    start_val = W'($urandom);
    end_val   = W'($urandom);
  endtask

  // One sequence from an IDLE start. pa/plen: raise pause for plen cycles once
  // c counts are done (pa<0 = never). ab: abort once ab counts are done (<0 = never).
  task automatic run_seq(input int s, input int e, input int pa, input int plen,
                         input int ab, input bit pause_in_load);
    int  n, c, pleft;
    bit  resume, pdone, finished;
    n = (e - s + M) % M;
    c = 0; pleft = 0; resume = 0; pdone = 0; finished = 0;

    nxt;
    start = 1'b1; abort = 1'b0; pause = 1'b0;
    start_val = W'(s); end_val = W'(e);
    smp;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_en", 32'(cnt_en), 0);

    nxt;
    scramble();
    pause = pause_in_load;
    smp;
    chk("load_pulse", 32'(cnt_load), 1);
    chk("load_d", 32'(cnt_d), 32'(s));
    chk("load_en", 32'(cnt_en), 0);
    chk("load_busy", 32'(busy), 1);

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      nxt;
      scramble();
      pause = 1'b0;
      abort = 1'b0;
      if (c == ab) begin
        abort = 1'b1;
        smp;
        chk("abort_en", 32'(cnt_en), 0);
        chk("abort_load", 32'(cnt_load), 0);
        nxt;
        start = 1'b0; abort = 1'b0;
        smp;
        chk("abort_idle_busy", 32'(busy), 0);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_steps", 32'(steps), 32'(ab));
        chk("abort_wrapped", 32'(wrapped), 32'(s + ab >= M));
        nxt;
        smp;
        chk("abort_no_done2", 32'(done), 0);
        return;
      end
      if (c == pa && !pdone && pleft == 0 && !resume) pleft = plen;
      if (pleft > 0) begin
        pause = 1'b1;
        smp;
        chk("pause_en", 32'(cnt_en), 0);
        chk("pause_q", 32'(cnt_q), 32'((s + c) % M));
        pleft--;
        if (pleft == 0) resume = 1;
      end else if (resume) begin
        // Pause has dropped but the block leaves PAUSE only on this edge.
        smp;
        chk("resume_en", 32'(cnt_en), 0);
        resume = 0;
        pdone = 1;
      end else if (c == n) begin
        smp;
        chk("end_en", 32'(cnt_en), 0);
        chk("end_busy", 32'(busy), 1);
        finished = 1;
      end else begin
        smp;
        chk("run_en", 32'(cnt_en), 1);
        chk("run_load", 32'(cnt_load), 0);
        chk("run_q", 32'(cnt_q), 32'((s + c) % M));
        c++;
      end
    end
    chk("seq_budget", 32'(finished), 1);

    nxt;
    scramble();
    abort = 1'($urandom_range(0, 1));
    smp;
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_steps", 32'(steps), 32'(n));
    chk("done_wrapped", 32'(wrapped), 32'(s + n >= M));

    nxt;
    start = 1'b0; abort = 1'b0;
    smp;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_steps", 32'(steps), 32'(n));
    chk("post_q_held", 32'(cnt_q), 32'(e));
  endtask

  initial begin
    int s, n, e, pa, plen, ab, sel;

    repeat (2) @(posedge CLK);
    smp;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(cnt_en), 0);
    chk("rst_load", 32'(cnt_load), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_d", 32'(cnt_d), 0);
    chk("rst_steps", 32'(steps), 0);
    chk("rst_wrapped", 32'(wrapped), 0);
    nxt;
    RST = 1'b1;
    smp;
    chk("rel_busy", 32'(busy), 0);
    repeat (5) begin
      nxt;
      smp;
      chk("idle_busy5", 32'(busy), 0);
      chk("idle_en5", 32'(cnt_en), 0);
    end

    run_seq(3, 10, -1, 0, -1, 0);
    run_seq(12'hFFD, 12'h002, -1, 0, -1, 0);
    run_seq(0, 6, 2, 4, -1, 0);
    run_seq(0, 100, -1, 0, 20, 0);
    run_seq(5, 5, -1, 0, -1, 1);

    nxt;
    start = 1'b1; abort = 1'b1; start_val = 12'd1; end_val = 12'd9;
    smp;
    nxt;
    start = 1'b0; abort = 1'b0;
    smp;
    chk("start_abort_load", 32'(cnt_load), 0);
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_steps", 32'(steps), 0);

    for (int i = 0; i < 25; i++) begin
      s  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, M - 1)) : M - int'($urandom_range(1, 20));
      n  = int'($urandom_range(0, 30));
      e  = (s + n) % M;
      pa = -1; plen = 0; ab = -1;
      sel = int'($urandom_range(0, 3));
      if (sel == 1 && n > 0) ab = int'($urandom_range(0, n - 1));
      else if (sel == 2 && n > 0) begin
        pa   = int'($urandom_range(0, n - 1));
        plen = int'($urandom_range(1, 5));
      end
      run_seq(s, e, pa, plen, ab, 1'($urandom_range(0, 1)));
    end

    nxt;
    start = 1'b1; start_val = 12'd100; end_val = 12'd200;
    smp;
    nxt;
    start = 1'b0;
    repeat (6) begin
      nxt;
      smp;
    end
    #2 RST = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_en", 32'(cnt_en), 0);
    chk("async_steps", 32'(steps), 0);
    chk("async_wrapped", 32'(wrapped), 0);
    nxt;
    RST = 1'b1;
    smp;
    chk("async_rel_busy", 32'(busy), 0);
    run_seq(4090, 3, -1, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
